multicycle_control: RTL and testbench

Multi-cycle sequencer for the 8-bit LD microprocessor datapath (register file, ALU, data memory, PC counter). It replaces the single-cycle decode with an FSM. The FSM fetches one instruction byte over a request/acknowledge handshake and latches it into an internal IR. It then steps the instruction through DECODE/EXEC/MEM/WB, driving the datapath strobes, handshaking with data memory, and reporting infinite-loop, overflow and bus-timeout conditions.

---
 rtl/multicycle_control.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the 8-bit LD datapath: fetches one instruction byte,
// then walks it through DECODE/EXEC/MEM/WB with bus-timeout supervision.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instruction,
    output logic       fetch_req,
    input  logic       fetch_ack,
    output logic       mem_req,
    input  logic       mem_ack,
    input  logic       alu_of,
    output logic [7:0] ir,
    output logic       sigBranch,
    output logic       sigMemtoReg,
    output logic       sigMemRead,
    output logic       sigMemWrite,
    output logic       sigALUOp,
    output logic       sigALUSrc,
    output logic       sigRegWrite,
    output logic       sigRegDst,
    output logic       pc_en,
    output logic [2:0] state,
    output logic [1:0] flags,
    output logic       bus_err,
    output logic [7:0] retired
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_JUMP  = 2'b11;
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q;
    logic [7:0] ir_q;
    logic [1:0] flags_q;
    logic       bus_err_q;
    logic [7:0] retired_q;
    logic [7:0] tmo_q;
    logic [1:0] op;
    logic       tmo_hit;

    assign op      = ir_q[7:6];
    // The last permitted wait cycle; an ack in this same cycle still wins.
    assign tmo_hit = (tmo_q == TMO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            flags_q   <= '0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
            tmo_q     <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (fetch_ack) begin
                        ir_q    <= instruction;
                        tmo_q   <= '0;
                        state_q <= S_DECODE;
                    end else if (tmo_hit) begin
                        bus_err_q <= 1'b1;
                        tmo_q     <= '0;
                        state_q   <= S_HALT;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                S_DECODE: state_q <= S_EXEC;
                S_EXEC: begin
                    case (op)
                        OP_ADD: begin
                            if (alu_of) flags_q[1] <= 1'b1;
                            state_q <= S_WB;
                        end
                        OP_LOAD, OP_STORE: state_q <= S_MEM;
                        default: begin
                            retired_q <= retired_q + 8'd1;
                            if (ir_q[1:0] == 2'b11) begin
                                flags_q[0] <= 1'b1;
                                state_q    <= S_HALT;
                            end else begin
                                state_q <= S_FETCH;
                            end
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        tmo_q <= '0;
                        if (op == OP_LOAD) begin
                            state_q <= S_WB;
                        end else begin
                            retired_q <= retired_q + 8'd1;
                            state_q   <= S_FETCH;
                        end
                    end else if (tmo_hit) begin
                        bus_err_q <= 1'b1;
                        tmo_q     <= '0;
                        state_q   <= S_HALT;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                S_WB: begin
                    retired_q <= retired_q + 8'd1;
                    state_q   <= S_FETCH;
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_HALT;
            endcase
        end
    end

    // Strobes decode from state and IR; only the store's pc_en depends on mem_ack.
    always_comb begin
        fetch_req   = 1'b0;
        mem_req     = 1'b0;
        sigBranch   = 1'b0;
        sigMemtoReg = 1'b0;
        sigMemRead  = 1'b0;
        sigMemWrite = 1'b0;
        sigALUOp    = 1'b0;
        sigALUSrc   = 1'b0;
        sigRegWrite = 1'b0;
        sigRegDst   = 1'b0;
        pc_en       = 1'b0;
        case (state_q)
            S_FETCH: fetch_req = ~reset;
            S_EXEC: begin
                case (op)
                    OP_ADD: begin
                        sigALUOp  = 1'b1;
                        sigRegDst = 1'b1;
                    end
                    OP_LOAD, OP_STORE: sigALUSrc = 1'b1;
                    default: begin
                        sigBranch = 1'b1;
                        pc_en     = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                mem_req   = 1'b1;
                sigALUSrc = 1'b1;
                if (op == OP_LOAD) begin
                    sigMemRead = 1'b1;
                end else begin
                    sigMemWrite = 1'b1;
                    pc_en       = mem_ack;
                end
            end
            S_WB: begin
                sigRegWrite = 1'b1;
                pc_en       = 1'b1;
                if (op == OP_LOAD) begin
                    sigMemtoReg = 1'b1;
                end else begin
                    sigALUOp  = 1'b1;
                    sigRegDst = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign ir      = ir_q;
    assign flags   = flags_q;
    assign bus_err = bus_err_q;
    assign retired = retired_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus
// hand-written timeout and reset-abort sequences.
module tb_multicycle_control;
    localparam int MT = 15;

    logic       clk;
    logic       reset;
    logic [7:0] instruction;
    logic       fetch_req, fetch_ack, mem_req, mem_ack, alu_of;
    logic [7:0] ir;
    logic       sigBranch, sigMemtoReg, sigMemRead, sigMemWrite;
    logic       sigALUOp, sigALUSrc, sigRegWrite, sigRegDst, pc_en;
    logic [2:0] state;
    logic [1:0] flags;
    logic       bus_err;
    logic [7:0] retired;

    multicycle_control #(.MEM_TIMEOUT(MT)) dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .fetch_req(fetch_req), .fetch_ack(fetch_ack),
        .mem_req(mem_req), .mem_ack(mem_ack), .alu_of(alu_of), .ir(ir),
        .sigBranch(sigBranch), .sigMemtoReg(sigMemtoReg), .sigMemRead(sigMemRead),
        .sigMemWrite(sigMemWrite), .sigALUOp(sigALUOp), .sigALUSrc(sigALUSrc),
        .sigRegWrite(sigRegWrite), .sigRegDst(sigRegDst), .pc_en(pc_en),
        .state(state), .flags(flags), .bus_err(bus_err), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe vector order: {Branch, MemtoReg, MemRead, MemWrite, ALUOp, ALUSrc, RegWrite, RegDst}
    localparam logic [7:0] NONE   = 8'b0000_0000;
    localparam logic [7:0] EXADD  = 8'b0000_1001;
    localparam logic [7:0] EXLS   = 8'b0000_0100;
    localparam logic [7:0] EXJ    = 8'b1000_0000;
    localparam logic [7:0] MEMLD  = 8'b0010_0100;
    localparam logic [7:0] MEMST  = 8'b0001_0100;
    localparam logic [7:0] WBADD  = 8'b0000_1011;
    localparam logic [7:0] WBLD   = 8'b0100_0010;
    localparam logic [7:0] I_ADD  = 8'h1B;
    localparam logic [7:0] I_LD   = 8'h45;
    localparam logic [7:0] I_ST   = 8'h84;
    localparam logic [7:0] I_JP   = 8'hC1;
    localparam logic [7:0] I_JS   = 8'hC3;

    typedef struct {
        logic       rst;
        logic [7:0] instr;
        logic       fa, ma, ao;
        logic [2:0] st;
        logic       fr, mr, pe;
        logic [7:0] strb;
        logic [1:0] flg;
        logic       be;
        logic [7:0] ret;
        logic [7:0] irx;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(logic r, logic [7:0] in, logic fa, logic ma, logic ao,
                                logic [2:0] st, logic fr, logic mr, logic pe,
                                logic [7:0] strb, logic [1:0] flg, logic be,
                                logic [7:0] ret, logic [7:0] irx);
        vec_t v;
        v.rst = r; v.instr = in; v.fa = fa; v.ma = ma; v.ao = ao;
        v.st = st; v.fr = fr; v.mr = mr; v.pe = pe; v.strb = strb;
        v.flg = flg; v.be = be; v.ret = ret; v.irx = irx;
        return v;
    endfunction

    function automatic logic [7:0] strobes();
        return {sigBranch, sigMemtoReg, sigMemRead, sigMemWrite,
                sigALUOp, sigALUSrc, sigRegWrite, sigRegDst};
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
    endtask

    task automatic cyc(input logic r, input logic [7:0] in, input logic fa, input logic ma, input logic ao);
        @(negedge clk);
        reset = r; instruction = in; fetch_ack = fa; mem_ack = ma; alu_of = ao;
        #1;
    endtask

    initial begin
        reset = 1'b1; instruction = '0; fetch_ack = 1'b0; mem_ack = 1'b0; alu_of = 1'b0;

        //           r  instr  fa ma ao  st fr mr pe strb   flg be ret irx
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, NONE,  0, 0, 0, 8'h00)); // 0 reset
        tbl.push_back(mk(0, I_ADD, 1, 0, 0, 0, 1, 0, 0, NONE,  0, 0, 0, 8'h00)); // 1 fetch add
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, NONE,  0, 0, 0, I_ADD));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 2, 0, 0, 0, EXADD, 0, 0, 0, I_ADD));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 4, 0, 0, 1, WBADD, 0, 0, 0, I_ADD));
        tbl.push_back(mk(0, I_LD,  1, 0, 0, 0, 1, 0, 0, NONE,  0, 0, 1, I_ADD)); // 5 fetch load
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, NONE,  0, 0, 1, I_LD));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 2, 0, 0, 0, EXLS,  0, 0, 1, I_LD));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 3, 0, 1, 0, MEMLD, 0, 0, 1, I_LD));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 3, 0, 1, 0, MEMLD, 0, 0, 1, I_LD));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 3, 0, 1, 0, MEMLD, 0, 0, 1, I_LD));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 3, 0, 1, 0, MEMLD, 0, 0, 1, I_LD));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 4, 0, 0, 1, WBLD,  0, 0, 1, I_LD));
        tbl.push_back(mk(0, I_ST,  1, 0, 0, 0, 1, 0, 0, NONE,  0, 0, 2, I_LD));  // 13 fetch store
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, NONE,  0, 0, 2, I_ST));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 2, 0, 0, 0, EXLS,  0, 0, 2, I_ST));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 3, 0, 1, 1, MEMST, 0, 0, 2, I_ST));
        tbl.push_back(mk(0, I_ADD, 1, 0, 0, 0, 1, 0, 0, NONE,  0, 0, 3, I_ST));  // 17 add, overflow
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, NONE,  0, 0, 3, I_ADD));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 2, 0, 0, 0, EXADD, 0, 0, 3, I_ADD));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 4, 0, 0, 1, WBADD, 2, 0, 3, I_ADD));
        tbl.push_back(mk(0, I_ADD, 1, 0, 0, 0, 1, 0, 0, NONE,  2, 0, 4, I_ADD)); // 21 add, no overflow
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, NONE,  2, 0, 4, I_ADD));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 2, 0, 0, 0, EXADD, 2, 0, 4, I_ADD));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 4, 0, 0, 1, WBADD, 2, 0, 4, I_ADD));
        tbl.push_back(mk(0, I_JP,  1, 0, 0, 0, 1, 0, 0, NONE,  2, 0, 5, I_ADD)); // 25 jump +1
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, NONE,  2, 0, 5, I_JP));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 2, 0, 0, 1, EXJ,   2, 0, 5, I_JP));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, NONE,  2, 0, 6, I_JP));  // 28 fetch waits
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, NONE,  2, 0, 6, I_JP));
        tbl.push_back(mk(0, I_JS,  1, 0, 0, 0, 1, 0, 0, NONE,  2, 0, 6, I_JP));  // 30 self-loop jump
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, NONE,  2, 0, 6, I_JS));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 2, 0, 0, 1, EXJ,   2, 0, 6, I_JS));
        tbl.push_back(mk(0, I_ADD, 1, 1, 0, 5, 0, 0, 0, NONE,  3, 0, 7, I_JS));  // 33 halt ignores acks
        tbl.push_back(mk(0, I_ADD, 1, 1, 0, 5, 0, 0, 0, NONE,  3, 0, 7, I_JS));
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, NONE,  0, 0, 0, 8'h00)); // 35 reset clears

        foreach (tbl[k]) begin
            cyc(tbl[k].rst, tbl[k].instr, tbl[k].fa, tbl[k].ma, tbl[k].ao);
            chk("state",     k, 8'(state),     8'(tbl[k].st));
            chk("fetch_req", k, 8'(fetch_req), 8'(tbl[k].fr));
            chk("mem_req",   k, 8'(mem_req),   8'(tbl[k].mr));
            chk("pc_en",     k, 8'(pc_en),     8'(tbl[k].pe));
            chk("strobes",   k, strobes(),     tbl[k].strb);
            chk("flags",     k, 8'(flags),     8'(tbl[k].flg));
            chk("bus_err",   k, 8'(bus_err),   8'(tbl[k].be));
            chk("retired",   k, retired,       tbl[k].ret);
            chk("ir",        k, ir,            tbl[k].irx);
        end

        // Fetch timeout: MT cycles without fetch_ack end in HALT with bus_err.
        cyc(1, 8'h00, 0, 0, 0);
        for (int k = 0; k < MT; k++) begin
            cyc(0, 8'h00, 0, 0, 0);
            chk("fto_state", k, 8'(state), 8'd0);
            chk("fto_pc_en", k, 8'(pc_en), 8'd0);
            chk("fto_berr",  k, 8'(bus_err), 8'd0);
        end
        cyc(0, 8'h00, 0, 0, 0);
        chk("fto_halt",  0, 8'(state), 8'd5);
        chk("fto_berr",  MT, 8'(bus_err), 8'd1);
        chk("fto_freq",  0, 8'(fetch_req), 8'd0);
        chk("fto_pc_en", MT, 8'(pc_en), 8'd0);

        // Ack on the limit cycle wins; then a MEM-side timeout on the load.
        cyc(1, 8'h00, 0, 0, 0);
        for (int k = 0; k < MT - 1; k++) cyc(0, 8'h00, 0, 0, 0);
        cyc(0, I_LD, 1, 0, 0);
        chk("lim_state", 0, 8'(state), 8'd0);
        cyc(0, 8'h00, 0, 0, 0);
        chk("lim_state", 1, 8'(state), 8'd1);
        chk("lim_berr",  1, 8'(bus_err), 8'd0);
        chk("lim_ir",    1, ir, I_LD);
        cyc(0, 8'h00, 0, 0, 0);
        chk("lim_state", 2, 8'(state), 8'd2);
        for (int k = 0; k < MT; k++) begin
            cyc(0, 8'h00, 0, 0, 0);
            chk("mto_state", k, 8'(state), 8'd3);
            chk("mto_mreq",  k, 8'(mem_req), 8'd1);
            chk("mto_pc_en", k, 8'(pc_en), 8'd0);
        end
        cyc(0, 8'h00, 0, 1, 0);
        chk("mto_halt", 0, 8'(state), 8'd5);
        chk("mto_berr", 0, 8'(bus_err), 8'd1);
        chk("mto_mreq", MT, 8'(mem_req), 8'd0);
        chk("mto_ret",  0, retired, 8'd0);

        // Reset asserted mid-cycle while a load sits in MEM aborts it.
        cyc(1, 8'h00, 0, 0, 0);
        cyc(0, I_LD, 1, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);
        chk("abort_mem", 0, 8'(state), 8'd3);
        #2 reset = 1'b1;
        #1;
        chk("abort_state", 0, 8'(state), 8'd0);
        chk("abort_strb",  0, strobes(), NONE);
        chk("abort_freq",  0, 8'(fetch_req), 8'd0);
        chk("abort_mreq",  0, 8'(mem_req), 8'd0);
        cyc(1, 8'h00, 0, 1, 0);
        chk("abort_pc_en", 1, 8'(pc_en), 8'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 8'h00, 0, 1, 0);
            chk("post_state", k, 8'(state), 8'd0);
            chk("post_freq",  k, 8'(fetch_req), 8'd1);
            chk("post_rw",    k, 8'(sigRegWrite), 8'd0);
            chk("post_ret",   k, retired, 8'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
